// File: rtl/frame_grabber.sv
// Assembles one MATRIX_N x MATRIX_M camera frame into a flat vector and holds it until downstream acknowledges.
// Optional dropped-frame counter is enabled by defining FRAME_GRABBER_DROP_CNT_EN.
module frame_grabber #(
    parameter int IMAGE_BITS = 8,
    parameter int MATRIX_N   = 120,
    parameter int MATRIX_M   = 120,
    parameter int FLAT_WIDE  = IMAGE_BITS * MATRIX_N * MATRIX_M
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [IMAGE_BITS-1:0] PixData,
    input  logic                  PixValid,
    input  logic                  FrameStart,
    input  logic                  AckOut,
    output logic                  ReqOut,
    output logic [FLAT_WIDE-1:0]  ImgMat,
    output logic                  Busy,
    output logic [7:0]            DropCnt
);

    localparam int NPIX  = MATRIX_N * MATRIX_M;
    localparam int COL_W = (MATRIX_N > 1) ? $clog2(MATRIX_N) : 1;
    localparam int ROW_W = (MATRIX_M > 1) ? $clog2(MATRIX_M) : 1;
    localparam int K_W   = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MATRIX_N - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MATRIX_M - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NPIX - 1);
    localparam logic [K_W-1:0]   N_K      = K_W'(MATRIX_N);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} stateT;

    stateT            state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic             startNow;
    logic             doWrite;
    logic             lastPix;
    logic [COL_W-1:0] wrCol;
    logic [ROW_W-1:0] wrRow;
    logic [COL_W-1:0] nextCol;
    logic [ROW_W-1:0] nextRow;
    logic [K_W-1:0]   wrIdx;

    // A FrameStart in IDLE or CAPTURE rebases the write position to pixel 0 for the same-cycle pixel.
    always_comb begin
        startNow = FrameStart && (state != HOLD);
        doWrite  = PixValid && ((state == CAPTURE) || (state == IDLE && FrameStart));
        wrCol    = startNow ? '0 : col;
        wrRow    = startNow ? '0 : row;
        wrIdx    = K_W'(wrRow) * N_K + K_W'(wrCol);
        lastPix  = (wrIdx == K_LAST);
        nextCol  = (wrCol == COL_LAST) ? '0 : wrCol + COL_W'(1);
        nextRow  = wrRow;
        if (wrCol == COL_LAST) begin
            nextRow = (wrRow == ROW_LAST) ? '0 : wrRow + ROW_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            ReqOut <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (AckOut) begin
                        state  <= IDLE;
                        ReqOut <= 1'b0;
                    end
                end
                default: begin
                    if (state == CAPTURE || FrameStart) begin
                        if (doWrite && lastPix) begin
                            state  <= HOLD;
                            ReqOut <= 1'b1;
                            Busy   <= 1'b0;
                            col    <= '0;
                            row    <= '0;
                        end else begin
                            state <= CAPTURE;
                            Busy  <= 1'b1;
                            col   <= doWrite ? nextCol : wrCol;
                            row   <= doWrite ? nextRow : wrRow;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: the frame store is cleared by reset so a discarded frame never leaks downstream.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ImgMat <= '0;
        end else if (doWrite) begin
            ImgMat[int'(wrIdx) * IMAGE_BITS +: IMAGE_BITS] <= PixData;
        end
    end

`ifdef FRAME_GRABBER_DROP_CNT_EN
    logic dropEvent;

    assign dropEvent = FrameStart && (state == CAPTURE || state == HOLD);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            DropCnt <= '0;
        end else if (dropEvent && DropCnt != 8'hFF) begin
            DropCnt <= DropCnt + 8'd1;
        end
    end
`else
    assign DropCnt = '0;
`endif

endmodule

// File: tb/tb_frame_grabber.sv
// Directed bench for frame_grabber (4x2 pixels, 8 bits) with a frame-level reference model and per-cycle compare.
module tb_frame_grabber;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  PixData = '0;
    logic        PixValid = 1'b0;
    logic        FrameStart = 1'b0;
    logic        AckOut = 1'b0;
    logic        ReqOut;
    logic [63:0] ImgMat;
    logic        Busy;
    logic [7:0]  DropCnt;

    int checks = 0;
    int errors = 0;

    frame_grabber #(
        .IMAGE_BITS(8),
        .MATRIX_N(4),
        .MATRIX_M(2),
        .FLAT_WIDE(64)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .PixData(PixData),
        .PixValid(PixValid),
        .FrameStart(FrameStart),
        .AckOut(AckOut),
        .ReqOut(ReqOut),
        .ImgMat(ImgMat),
        .Busy(Busy),
        .DropCnt(DropCnt)
    );

    always #5 Clk = ~Clk;

    // Reference model: mode 0 = waiting, 1 = capturing, 2 = holding; linear pixel index.
    int          mMode = 0;
    int          mK = 0;
    logic [63:0] mImg = '0;
    int          mDrop = 0;

    function automatic logic [7:0] expDrop();
`ifdef FRAME_GRABBER_DROP_CNT_EN
        return 8'(mDrop);
`else
        return 8'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0;
        mK    = 0;
        mImg  = '0;
        mDrop = 0;
    endtask

    task automatic modelTake(input logic pv, input logic [7:0] d);
        mMode = 1;
        if (pv) begin
            mImg[mK*8 +: 8] = d;
            if (mK == 7) begin
                mMode = 2;
                mK    = 0;
            end else begin
                mK++;
            end
        end
    endtask

    task automatic modelStep(input logic fs, input logic pv, input logic [7:0] d, input logic ack);
        case (mMode)
            0: if (fs) begin
                mK = 0;
                modelTake(pv, d);
            end
            1: begin
                if (fs) begin
                    mK = 0;
                    if (mDrop < 255) mDrop++;
                end
                modelTake(pv, d);
            end
            default: begin
                if (fs && mDrop < 255) mDrop++;
                if (ack) mMode = 0;
            end
        endcase
    endtask

    // One clock of stimulus; model advances on the same edge the DUT samples.
    task automatic cyc(input logic fs, input logic pv, input logic [7:0] d, input logic ack);
        FrameStart = fs;
        PixValid   = pv;
        PixData    = d;
        AckOut     = ack;
        @(posedge Clk);
        modelStep(fs, pv, d, ack);
        #1;
        FrameStart = 1'b0;
        PixValid   = 1'b0;
        AckOut     = 1'b0;
    endtask

    task automatic fullFrame(input logic [7:0] base);
        cyc(1'b1, 1'b1, base, 1'b0);
        for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, base + 8'(i), 1'b0);
    endtask

    bit running = 1'b1;

    initial begin
        while (running) begin
            @(negedge Clk);
            if (running) begin
                check("ReqOut", 64'(ReqOut), 64'(mMode == 2));
                check("Busy", 64'(Busy), 64'(mMode == 1));
                check("ImgMat", ImgMat, mImg);
                check("DropCnt", 64'(DropCnt), 64'(expDrop()));
            end
        end
    end

    initial begin
        modelReset();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_ReqOut", 64'(ReqOut), 64'd0);
        check("rst_ImgMat", ImgMat, 64'd0);
        check("rst_DropCnt", 64'(DropCnt), 64'd0);
        Reset = 1'b1;

        // Pixels without FrameStart in IDLE are ignored.
        cyc(1'b0, 1'b1, 8'hAA, 1'b0);
        cyc(1'b0, 1'b1, 8'hAB, 1'b1);
        check("idle_ignore", ImgMat, 64'd0);

        // Back-to-back frame; ReqOut one cycle after the final pixel edge.
        fullFrame(8'h00);
        check("b2b_req", 64'(ReqOut), 64'd1);
        check("b2b_img", ImgMat, 64'h0706050403020100);
        check("model_b2b", mImg, 64'h0706050403020100);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("ack_req_low", 64'(ReqOut), 64'd0);

        // Gapped frame; AckOut during capture must be ignored.
        cyc(1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 1'b0, 8'hEE, 1'b1);
            check("gap_busy", 64'(Busy), 64'd1);
            cyc(1'b0, 1'b1, 8'(i), 1'b0);
        end
        check("gap_img", ImgMat, 64'h0706050403020100);
        check("gap_req", 64'(ReqOut), 64'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Abort after 3 pixels, then a full frame.
        cyc(1'b1, 1'b1, 8'h20, 1'b0);
        cyc(1'b0, 1'b1, 8'h21, 1'b0);
        cyc(1'b0, 1'b1, 8'h22, 1'b0);
        fullFrame(8'h10);
        check("abort_img", ImgMat, 64'h1716151413121110);
`ifdef FRAME_GRABBER_DROP_CNT_EN
        check("abort_drop", 64'(DropCnt), 64'd1);
`else
        check("abort_drop", 64'(DropCnt), 64'd0);
`endif

        // HOLD ignores a new frame but counts it.
        fullFrame(8'hFF);
        check("hold_img", ImgMat, 64'h1716151413121110);
        check("hold_req", 64'(ReqOut), 64'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("hold_ack_req", 64'(ReqOut), 64'd0);
        check("hold_ack_busy", 64'(Busy), 64'd0);

        // FrameStart on the final-pixel cycle restarts instead of completing.
        cyc(1'b1, 1'b1, 8'h30, 1'b0);
        for (int i = 1; i < 7; i++) cyc(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
        cyc(1'b1, 1'b1, 8'h40, 1'b0);
        check("last_restart_req", 64'(ReqOut), 64'd0);
        for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0);
        check("last_restart_img", ImgMat, 64'h4746454443424140);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset mid-capture discards everything.
        cyc(1'b1, 1'b1, 8'h90, 1'b0);
        for (int i = 1; i < 5; i++) cyc(1'b0, 1'b1, 8'h90 + 8'(i), 1'b0);
        Reset = 1'b0;
        modelReset();
        #1;
        check("mid_rst_img", ImgMat, 64'd0);
        check("mid_rst_req", 64'(ReqOut), 64'd0);
        check("mid_rst_drop", 64'(DropCnt), 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        fullFrame(8'h50);
        check("post_rst_img", ImgMat, 64'h5756555453525150);

        // Reset while holding a frame.
        Reset = 1'b0;
        modelReset();
        #1;
        check("hold_rst_req", 64'(ReqOut), 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;

        // FrameStart without a pixel, then eight pixels.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0);
        check("fs_nopix_img", ImgMat, 64'h6766656463626160);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
`ifdef FRAME_GRABBER_DROP_CNT_EN
        check("drop_sat", 64'(DropCnt), 64'd255);
`else
        check("drop_off", 64'(DropCnt), 64'd0);
`endif

        running = 1'b0;
        @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_grabber.md
FRAME_GRABBER -- requirements
Module: frame_grabber

Interface
REQ-001 Parameter IMAGE_BITS, default 8, bits per pixel.
REQ-002 Parameter MATRIX_N, default 120, pixels across.
REQ-003 Parameter MATRIX_M, default 120, pixels down.
REQ-004 Parameter FLAT_WIDE, default IMAGE_BITS*MATRIX_N*MATRIX_M, flattened frame width.
REQ-005 Clk  input  1  clock; reset Reset, asynchronous, active-low.
REQ-006 Reset  input  1  asynchronous active-low reset.
REQ-007 PixData  input  IMAGE_BITS  pixel from the camera stream.
REQ-008 PixValid  input  1  PixData valid this cycle.
REQ-009 FrameStart  input  1  single-cycle start-of-frame marker, qualifies the same-cycle pixel.
REQ-010 AckOut  input  1  acknowledge from the downstream camera handler stage.
REQ-011 ReqOut  output  1  complete frame held, request to downstream.
REQ-012 ImgMat  output  FLAT_WIDE  assembled frame, feeds downstream CameraData.
REQ-013 Busy  output  1  capture in progress.
REQ-014 DropCnt  output  8  dropped-frame count.

Function
REQ-015 States: IDLE, CAPTURE, HOLD; encoding free.
REQ-016 IDLE: PixValid without FrameStart is ignored.
REQ-017 IDLE, FrameStart&PixValid: store pixel 0, col=1, row=0, go to CAPTURE; FrameStart without PixValid: col=0, row=0, go to CAPTURE.
REQ-018 CAPTURE: each PixValid cycle writes PixData to ImgMat[k*IMAGE_BITS +: IMAGE_BITS], k=row*MATRIX_N+col.
REQ-019 col wraps MATRIX_N-1 -> 0 with row+1; counters sized ceil(log2) of N and M.
REQ-020 Write of k=MATRIX_N*MATRIX_M-1 moves to HOLD; ReqOut high the next cycle.
REQ-021 CAPTURE, FrameStart: abort the partial frame, restart at k=0 (same-cycle pixel is pixel 0 if PixValid); increment DropCnt.
REQ-022 FrameStart on the final-pixel cycle counts as restart (REQ-021) and does not enter HOLD.
REQ-023 HOLD: ReqOut=1; ImgMat frozen; all pixels ignored.
REQ-024 HOLD, FrameStart: frame not captured; increment DropCnt; remain HOLD.
REQ-025 HOLD, AckOut sampled high: go to IDLE; ReqOut low next cycle.
REQ-026 AckOut outside HOLD is ignored.
REQ-027 Busy=1 exactly in CAPTURE.
REQ-028 DropCnt saturates at 255, never wraps.
REQ-029 ImgMat not written outside CAPTURE/IDLE-start; unwritten pixels keep old values.
REQ-030 Latency: last pixel sample edge to ReqOut high = 1 cycle.

Reset
REQ-031 Reset low forces IDLE, ImgMat=0, ReqOut=0, Busy=0, DropCnt=0, counters=0 immediately.
REQ-032 Reset mid-CAPTURE or mid-HOLD discards the frame; no ReqOut until the next complete frame.

Configuration
REQ-033 Macro FRAME_GRABBER_DROP_CNT_EN defined: DropCnt per REQ-021, REQ-024, REQ-028.
REQ-034 Macro undefined: DropCnt tied to 0, no counter logic; all other behaviour identical.

Verification (IMAGE_BITS=8, MATRIX_N=4, MATRIX_M=2, macro defined)
REQ-035 FrameStart+PixValid with pixels 0x00..0x07 back-to-back -> ReqOut high 1 cycle after 0x07; ImgMat=0x0706050403020100.
REQ-036 Frame with PixValid gaps (every other cycle) -> same ImgMat; Busy high throughout capture.
REQ-037 FrameStart after 3 pixels, then full frame 0x10..0x17 -> ImgMat=0x1716151413121110; DropCnt=1.
REQ-038 In HOLD: FrameStart plus 8 pixels 0xFF -> ImgMat unchanged, DropCnt+1; AckOut pulse -> ReqOut low next cycle, IDLE.
REQ-039 Reset asserted after 5 pixels -> ImgMat=0, ReqOut=0, DropCnt=0; new full frame captures correctly.
REQ-040 300 aborting FrameStarts -> DropCnt holds 255; macro undefined -> DropCnt stays 0.
